// File: rtl/stepper_pkg.sv
// Shared definitions for the stepper sequencer.
//   MODE_*       : encodings of the 2-bit step mode input
//   state_e      : sequencer FSM states
//   COIL_TABLE   : 8-entry half-step coil pattern table, entry i = COIL_TABLE[i]
//   next_index() : phase index advance, including parity realignment after a mode change
package stepper_pkg;

    localparam logic [1:0] MODE_WAVE = 2'b00;
    localparam logic [1:0] MODE_FULL = 2'b01;
    localparam logic [1:0] MODE_HALF = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StMove = 2'd2
    } state_e;

    // Packed so that COIL_TABLE[i] is the pattern for phase index i (last literal = index 0).
    localparam logic [7:0][3:0] COIL_TABLE = {
        4'b1001, 4'b1000, 4'b1100, 4'b0100,
        4'b0110, 4'b0010, 4'b0011, 4'b0001
    };

    // Wave lives on even indices, full (two-coil) on odd ones. A single odd-sized
    // step realigns the index when it sits on the wrong parity for the current mode.
    function automatic logic [2:0] next_index(input logic [2:0] idx,
                                              input logic       dir,
                                              input logic [1:0] mode);
        logic [2:0] inc;
        if (mode == MODE_WAVE) begin
            inc = idx[0] ? 3'd1 : 3'd2;
        end else if (mode == MODE_FULL) begin
            inc = idx[0] ? 3'd2 : 3'd1;
        end else begin
            inc = 3'd1;
        end
        return dir ? (idx + inc) : (idx - inc);
    endfunction

endpackage

// File: rtl/step_rate_gen.sv
// Step-rate divider with minimum-period clamp.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : hold the divider at zero and suppress ticks
//   period_i   : requested clk cycles per step (clamped up to MIN_PERIOD)
//   tick_o     : combinational, high in the cycle the divider reaches eff_period-1
module step_rate_gen #(
    parameter int unsigned DIV_W      = 20,
    parameter int unsigned MIN_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic [DIV_W-1:0] period_i,
    output logic             tick_o
);

    localparam logic [DIV_W-1:0] MinPeriod = DIV_W'(MIN_PERIOD);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] eff_period;
    logic [DIV_W-1:0] eff_last;

    always_comb begin
        eff_period = (period_i < MinPeriod) ? MinPeriod : period_i;
        // Guard a zero period (only reachable with MIN_PERIOD = 0): step every cycle.
        eff_last   = (eff_period == '0) ? '0 : (eff_period - DIV_W'(1));
        // Compare with >= so a live period reduction below the count fires at once.
        tick_o     = !clr_i && (cnt_q >= eff_last);
        cnt_d      = (clr_i || tick_o) ? '0 : (cnt_q + DIV_W'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stepper_seq_ctrl.sv
// Unipolar 4-coil stepper sequencer: continuous run, counted moves, abort,
// wave/full/half stepping, coil hold and a signed position counter.
//   clk, rst_n     : system clock, asynchronous active-low reset
//   enable_i       : continuous run while high (ignored during a move)
//   start_i        : pulse, start a move of step_count_i steps (priority over enable_i)
//   abort_i        : pulse, terminate a counted move without done
//   step_count_i   : move length, sampled on start_i
//   dir_i, mode_i  : direction and step mode, sampled at each step
//   period_i       : clk cycles per step, clamped to MIN_PERIOD
//   hold_i         : keep last coil pattern while idle
//   coils_o        : coil drive, bit 0 = in1
//   step_tick_o    : pulse coincident with each coil update
//   busy_o         : high during a counted move
//   done_o         : pulse at the end of a counted move
//   position_o     : signed net step count
module stepper_seq_ctrl
    import stepper_pkg::*;
#(
    parameter int unsigned DIV_W      = 20,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned POS_W      = 24,
    parameter int unsigned MIN_PERIOD = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] step_count_i,
    input  logic             dir_i,
    input  logic [1:0]       mode_i,
    input  logic [DIV_W-1:0] period_i,
    input  logic             hold_i,
    output logic [3:0]       coils_o,
    output logic             step_tick_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [POS_W-1:0] position_o
);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [2:0]       idx_q, idx_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [3:0]       coils_q, coils_d;
    logic             tick_q, tick_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic rate_tick;
    logic step_fire;

    // Divider only counts while active, so it is already zero on entry to RUN/MOVE.
    step_rate_gen #(
        .DIV_W      (DIV_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_rate (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q == StIdle),
        .period_i (period_i),
        .tick_o   (rate_tick)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            rem_q   <= '0;
            idx_q   <= '0;
            pos_q   <= '0;
            coils_q <= '0;
            tick_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            pos_q   <= pos_d;
            coils_q <= coils_d;
            tick_q  <= tick_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        done_d    = 1'b0;
        step_fire = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    if (step_count_i == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = StMove;
                        rem_d   = step_count_i;
                    end
                end else if (enable_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!enable_i) begin
                    state_d = StIdle;
                end else begin
                    step_fire = rate_tick;
                end
            end
            StMove: begin
                if (abort_i) begin
                    // Abort wins over a step due in the same cycle.
                    state_d = StIdle;
                    rem_d   = '0;
                end else if (rate_tick) begin
                    step_fire = 1'b1;
                    rem_d     = rem_q - CNT_W'(1);
                    if (rem_q == CNT_W'(1)) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Output / datapath next values
    always_comb begin
        idx_d   = idx_q;
        pos_d   = pos_q;
        coils_d = coils_q;
        tick_d  = step_fire;
        busy_d  = (state_d == StMove);
        if (step_fire) begin
            idx_d   = next_index(idx_q, dir_i, mode_i);
            pos_d   = dir_i ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
            coils_d = COIL_TABLE[idx_d];
        end else if ((state_d == StIdle) && !hold_i) begin
            coils_d = '0;
        end
    end

    assign coils_o     = coils_q;
    assign step_tick_o = tick_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign position_o  = pos_q;

endmodule

// File: tb/tb_stepper_seq_ctrl.sv
module tb_stepper_seq_ctrl;

    localparam int unsigned DIV_W = 20;
    localparam int unsigned CNT_W = 16;
    localparam int unsigned POS_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable_i;
    logic             start_i;
    logic             abort_i;
    logic [CNT_W-1:0] step_count_i;
    logic             dir_i;
    logic [1:0]       mode_i;
    logic [DIV_W-1:0] period_i;
    logic             hold_i;
    logic [3:0]       coils_o;
    logic             step_tick_o;
    logic             busy_o;
    logic             done_o;
    logic [POS_W-1:0] position_o;

    int total = 0;
    int bad   = 0;
    int n;

    logic [3:0]       exp_half [4];
    logic [3:0]       exp_wave [4];
    logic [POS_W-1:0] exp_neg  [4];

    stepper_seq_ctrl u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable_i     (enable_i),
        .start_i      (start_i),
        .abort_i      (abort_i),
        .step_count_i (step_count_i),
        .dir_i        (dir_i),
        .mode_i       (mode_i),
        .period_i     (period_i),
        .hold_i       (hold_i),
        .coils_o      (coils_o),
        .step_tick_o  (step_tick_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .position_o   (position_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Returns cycles until the next step_tick, bounded at 5000.
    task automatic wait_tick(output int cycles);
        cycles = 0;
        do begin
            @(negedge clk);
            cycles++;
        end while (!step_tick_o && cycles < 5000);
    endtask

    task automatic pulse_start(input logic [CNT_W-1:0] cnt);
        step_count_i = cnt;
        start_i      = 1'b1;
        @(negedge clk);
        start_i      = 1'b0;
    endtask

    task automatic do_reset();
        enable_i = 1'b0;
        start_i  = 1'b0;
        abort_i  = 1'b0;
        rst_n    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n    = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        exp_half = '{4'b0011, 4'b0010, 4'b0110, 4'b0100};
        exp_wave = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
        exp_neg  = '{24'hFFFFFF, 24'hFFFFFE, 24'hFFFFFD, 24'hFFFFFC};

        step_count_i = '0;
        dir_i        = 1'b1;
        mode_i       = 2'b10;
        period_i     = 20'd1000;
        hold_i       = 1'b1;
        do_reset();

        // Reset state
        chk("rst_coils", 32'(coils_o), 32'h0);
        chk("rst_tick", 32'(step_tick_o), 32'h0);
        chk("rst_busy", 32'(busy_o), 32'h0);
        chk("rst_done", 32'(done_o), 32'h0);
        chk("rst_pos", 32'(position_o), 32'h0);

        // Counted half-step move of 4
        pulse_start(16'd4);
        chk("mv_busy", 32'(busy_o), 32'h1);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            chk("mv_gap", 32'(n), 32'd1000);
            chk("mv_coils", 32'(coils_o), 32'(exp_half[i]));
            chk("mv_done", 32'(done_o), (i == 3) ? 32'h1 : 32'h0);
        end
        chk("mv_pos", 32'(position_o), 32'd4);
        chk("mv_busy_end", 32'(busy_o), 32'h0);
        @(negedge clk);
        chk("mv_done_pulse", 32'(done_o), 32'h0);
        chk("mv_hold_coils", 32'(coils_o), 32'b0100);

        // Continuous wave run, reverse, period clamped up to the minimum
        do_reset();
        mode_i   = 2'b00;
        dir_i    = 1'b0;
        period_i = 20'd5;
        hold_i   = 1'b0;
        enable_i = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            wait_tick(n);
            chk("run_gap", 32'(n), 32'd1000);
            chk("run_coils", 32'(coils_o), 32'(exp_wave[i]));
            chk("run_pos", 32'(position_o), 32'(exp_neg[i]));
        end
        enable_i = 1'b0;
        @(negedge clk);
        chk("run_off_coils", 32'(coils_o), 32'h0);
        chk("run_off_tick", 32'(step_tick_o), 32'h0);

        // Mode realignment
        do_reset();
        period_i = 20'd1000;
        hold_i   = 1'b1;
        dir_i    = 1'b1;
        mode_i   = 2'b10;
        pulse_start(16'd1);
        wait_tick(n);
        chk("al_half", 32'(coils_o), 32'b0011);
        mode_i = 2'b00;
        @(negedge clk);
        pulse_start(16'd2);
        wait_tick(n);
        chk("al_wave1", 32'(coils_o), 32'b0010);
        wait_tick(n);
        chk("al_wave2", 32'(coils_o), 32'b0100);
        mode_i = 2'b01;
        @(negedge clk);
        pulse_start(16'd2);
        wait_tick(n);
        chk("al_full1", 32'(coils_o), 32'b1100);
        wait_tick(n);
        chk("al_full2", 32'(coils_o), 32'b1001);
        chk("al_pos", 32'(position_o), 32'd5);

        // Abort after 10 steps
        do_reset();
        mode_i = 2'b10;
        pulse_start(16'd100);
        for (int i = 0; i < 10; i++) begin
            wait_tick(n);
            chk("ab_gap", 32'(n), 32'd1000);
        end
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("ab_busy", 32'(busy_o), 32'h0);
        chk("ab_done", 32'(done_o), 32'h0);
        chk("ab_pos", 32'(position_o), 32'd10);
        @(negedge clk);
        chk("ab_done2", 32'(done_o), 32'h0);
        pulse_start(16'd3);
        chk("ab_restart", 32'(busy_o), 32'h1);

        // Zero-length move, then start+enable together, then async reset mid-move
        do_reset();
        pulse_start(16'd0);
        chk("z_done", 32'(done_o), 32'h1);
        chk("z_busy", 32'(busy_o), 32'h0);
        chk("z_tick", 32'(step_tick_o), 32'h0);
        @(negedge clk);
        chk("z_done_off", 32'(done_o), 32'h0);
        chk("z_busy2", 32'(busy_o), 32'h0);
        enable_i = 1'b1;
        pulse_start(16'd5);
        chk("se_busy", 32'(busy_o), 32'h1);
        wait_tick(n);
        chk("se_gap", 32'(n), 32'd1000);
        chk("se_coils", 32'(coils_o), 32'b0011);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_coils", 32'(coils_o), 32'h0);
        chk("ar_busy", 32'(busy_o), 32'h0);
        chk("ar_pos", 32'(position_o), 32'h0);
        chk("ar_tick", 32'(step_tick_o), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
